// File: rtl/btb_controller.sv
// BTB controller: owns an 8-set x 2-way branch target buffer array.
// - Serves fetch lookups with one cycle of latency.
// - Applies resolved-branch updates as a serialized read-modify-write.
// - Sweeps the array to zero after reset.
// Set layout:
// - way1 = [127:64], way0 = [63:0].
// - way fields: [63] valid, [62:36] tag, [35:6] target[31:2], [5:4] counter, [3:1] zero.
// - way0[0] is the set LRU bit (way to replace); way1[0] is zero.
module btb_controller #(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_SETS     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lookup_valid,
  output logic         lookup_ready,
  input  logic [31:0]  lookup_pc,
  output logic         pred_valid,
  output logic         pred_hit,
  output logic         pred_taken,
  output logic [31:0]  pred_target,
  input  logic         upd_valid,
  output logic         upd_ready,
  input  logic [31:0]  upd_pc,
  input  logic         upd_taken,
  input  logic [31:0]  upd_target,
  output logic [2:0]   read_index,
  input  logic [127:0] read_set,
  output logic [2:0]   write_index,
  output logic [127:0] write_set,
  output logic         write_enable,
  output logic         init_done
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_INIT      = 2'd0,
    S_IDLE      = 2'd1,
    S_UPD_READ  = 2'd2,
    S_UPD_WRITE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    sweep_q, sweep_d;
  logic          init_done_q, init_done_d;
  logic [CW-1:0] starve_q, starve_d;

  // Latched update request
  logic [26:0]   upd_tag_q, upd_tag_d;
  logic [2:0]    upd_idx_q, upd_idx_d;
  logic          upd_taken_q, upd_taken_d;
  logic [29:0]   upd_tgt_q, upd_tgt_d;

  // Registered prediction outputs
  logic          pred_valid_q, pred_valid_d;
  logic          pred_hit_q, pred_hit_d;
  logic          pred_taken_q, pred_taken_d;
  logic [31:0]   pred_target_q, pred_target_d;

  // Registered write port: INIT sweep and the write half of the RMW
  logic          we_q, we_d;
  logic [2:0]    widx_q, widx_d;
  logic [127:0]  wset_q, wset_d;

  logic          force_upd, upd_take, lookup_acc;
  logic [63:0]   way0, way1;
  logic          lk_hit0, lk_hit1;
  logic [63:0]   lk_way;

  logic          u_hit0, u_hit1, u_wr;
  logic [1:0]    u_cnt, u_cnt_n;
  logic          u_victim, u_lru;
  logic [63:0]   u_w0, u_w1, u_alloc;
  logic [127:0]  u_set;

  logic          unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign way0 = read_set[63:0];
  assign way1 = read_set[127:64];

  // The read port belongs to lookups unless a starved update forces it.
  // An idle lookup port also lets the update take it.
  assign force_upd    = (state_q == S_UPD_READ) && (starve_q == CW'(STARVE_LIMIT));
  assign upd_take     = (state_q == S_UPD_READ) && (!lookup_valid || force_upd);
  assign lookup_ready = init_done_q && !force_upd;
  assign upd_ready    = init_done_q && (state_q == S_IDLE);
  assign lookup_acc   = lookup_valid && lookup_ready;
  assign read_index   = upd_take ? upd_idx_q : lookup_pc[4:2];

  // Lookup tag compare. Both ways cannot hold the same tag, so way0 simply wins.
  always_comb begin
    lk_hit0 = way0[63] && (way0[62:36] == lookup_pc[31:5]);
    lk_hit1 = way1[63] && (way1[62:36] == lookup_pc[31:5]);
    lk_way  = lk_hit0 ? way0 : way1;
  end

  // Prediction register: pred_valid pulses per accept; the rest holds otherwise
  always_comb begin
    pred_valid_d  = lookup_acc;
    pred_hit_d    = pred_hit_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (lookup_acc) begin
      pred_hit_d    = lk_hit0 || lk_hit1;
      pred_taken_d  = (lk_hit0 || lk_hit1) && lk_way[5];
      pred_target_d = (lk_hit0 || lk_hit1) ? {lk_way[35:6], 2'b00} : 32'h0;
    end
  end

  // Update set computation from the set read this cycle
  always_comb begin
    u_hit0   = way0[63] && (way0[62:36] == upd_tag_q);
    u_hit1   = !u_hit0 && way1[63] && (way1[62:36] == upd_tag_q);
    u_cnt    = u_hit0 ? way0[5:4] : way1[5:4];
    u_cnt_n  = u_cnt;
    if (upd_taken_q) begin
      if (u_cnt != 2'd3) u_cnt_n = u_cnt + 2'd1;
    end else begin
      if (u_cnt != 2'd0) u_cnt_n = u_cnt - 2'd1;
    end
    u_alloc  = {1'b1, upd_tag_q, upd_tgt_q, 2'b10, 4'b0000};
    u_victim = !way0[63] ? 1'b0 : (!way1[63] ? 1'b1 : way0[0]);
    u_w0     = way0;
    u_w1     = way1;
    u_lru    = way0[0];
    u_wr     = 1'b0;
    if (u_hit0) begin
      u_wr       = 1'b1;
      u_w0[5:4]  = u_cnt_n;
      if (upd_taken_q) u_w0[35:6] = upd_tgt_q;
      u_lru      = 1'b1;
    end else if (u_hit1) begin
      u_wr       = 1'b1;
      u_w1[5:4]  = u_cnt_n;
      if (upd_taken_q) u_w1[35:6] = upd_tgt_q;
      u_lru      = 1'b0;
    end else if (upd_taken_q) begin
      u_wr = 1'b1;
      if (u_victim) u_w1 = u_alloc;
      else          u_w0 = u_alloc;
      u_lru = !u_victim;
    end
    u_w0[0] = u_lru;
    u_w1[0] = 1'b0;
    u_set   = {u_w1, u_w0};
  end

  // Controller FSM: init sweep, idle, update read (may starve), update write
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    starve_d    = starve_q;
    upd_tag_d   = upd_tag_q;
    upd_idx_d   = upd_idx_q;
    upd_taken_d = upd_taken_q;
    upd_tgt_d   = upd_tgt_q;
    we_d        = 1'b0;
    widx_d      = widx_q;
    wset_d      = wset_q;
    case (state_q)
      S_INIT: begin
        we_d    = 1'b1;
        widx_d  = sweep_q;
        wset_d  = '0;
        sweep_d = sweep_q + 3'd1;
        if (sweep_q == 3'(NUM_SETS - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        // First IDLE cycle carries the last sweep write; done rises after it
        init_done_d = 1'b1;
        if (upd_valid && upd_ready) begin
          upd_tag_d   = upd_pc[31:5];
          upd_idx_d   = upd_pc[4:2];
          upd_taken_d = upd_taken;
          upd_tgt_d   = upd_target[31:2];
          state_d     = S_UPD_READ;
        end
      end
      S_UPD_READ: begin
        if (upd_take) begin
          starve_d = '0;
          if (u_wr) begin
            we_d    = 1'b1;
            widx_d  = upd_idx_q;
            wset_d  = u_set;
            state_d = S_UPD_WRITE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          starve_d = starve_q + CW'(1);
        end
      end
      S_UPD_WRITE: state_d = S_IDLE;
      default:     state_d = S_INIT;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      sweep_q       <= '0;
      init_done_q   <= 1'b0;
      starve_q      <= '0;
      upd_tag_q     <= '0;
      upd_idx_q     <= '0;
      upd_taken_q   <= 1'b0;
      upd_tgt_q     <= '0;
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      we_q          <= 1'b0;
      widx_q        <= '0;
      wset_q        <= '0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      init_done_q   <= init_done_d;
      starve_q      <= starve_d;
      upd_tag_q     <= upd_tag_d;
      upd_idx_q     <= upd_idx_d;
      upd_taken_q   <= upd_taken_d;
      upd_tgt_q     <= upd_tgt_d;
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      we_q          <= we_d;
      widx_q        <= widx_d;
      wset_q        <= wset_d;
    end
  end

  assign pred_valid   = pred_valid_q;
  assign pred_hit     = pred_hit_q;
  assign pred_taken   = pred_taken_q;
  assign pred_target  = pred_target_q;
  assign write_enable = we_q;
  assign write_index  = widx_q;
  assign write_set    = wset_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_btb_controller.sv
// Bench for btb_controller.
// - Models the storage array with a same-cycle write bypass.
// - Keeps a reference BTB image that the update rules are applied to.
// - Scoreboards every accepted lookup against that image.
module tb_btb_controller;

  localparam int STARVE_LIMIT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lookup_valid = 1'b0;
  logic         lookup_ready;
  logic [31:0]  lookup_pc = '0;
  logic         pred_valid, pred_hit, pred_taken;
  logic [31:0]  pred_target;
  logic         upd_valid = 1'b0;
  logic         upd_ready;
  logic [31:0]  upd_pc = '0;
  logic         upd_taken = 1'b0;
  logic [31:0]  upd_target = '0;
  logic [2:0]   read_index;
  logic [127:0] read_set;
  logic [2:0]   write_index;
  logic [127:0] write_set;
  logic         write_enable;
  logic         init_done;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  logic [127:0] mem     [8];
  logic [127:0] ref_mem [8];
  pred_t        exp_q [$];
  pred_t        mon_e;
  int           n_cmp = 0;
  int           n_err = 0;

  btb_controller #(.STARVE_LIMIT(STARVE_LIMIT), .NUM_SETS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .read_index(read_index), .read_set(read_set),
    .write_index(write_index), .write_set(write_set), .write_enable(write_enable),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Storage array: combinational read with same-cycle write bypass
  assign read_set = (write_enable && write_index == read_index) ? write_set : mem[read_index];
  always @(posedge clk) if (write_enable) mem[write_index] <= write_set;

  function automatic logic [127:0] ref_apply(input logic [127:0] s, input logic [31:0] pc,
                                             input logic tk, input logic [31:0] tgt);
    logic [63:0] w [2];
    int h, v;
    logic lru;
    logic [1:0] c;
    w[0] = s[63:0];
    w[1] = s[127:64];
    lru = s[0];
    h = -1;
    v = 0;
    for (int i = 1; i >= 0; i--) if (w[i][63] && w[i][62:36] == pc[31:5]) h = i;
    if (h >= 0) begin
      c = w[h][5:4];
      if (tk) c = (c == 2'd3) ? c : c + 2'd1;
      else    c = (c == 2'd0) ? c : c - 2'd1;
      w[h][5:4] = c;
      if (tk) w[h][35:6] = tgt[31:2];
      lru = (h == 0);
    end else if (tk) begin
      if (!w[0][63])      v = 0;
      else if (!w[1][63]) v = 1;
      else                v = lru ? 1 : 0;
      w[v] = {1'b1, pc[31:5], tgt[31:2], 6'b100000};
      lru = (v == 0);
    end else begin
      return s;
    end
    w[0][0] = lru;
    w[1][0] = 1'b0;
    return {w[1], w[0]};
  endfunction

  function automatic pred_t ref_pred(input logic [31:0] pc);
    logic [127:0] s;
    logic [63:0] w;
    pred_t p;
    s = ref_mem[pc[4:2]];
    p = '0;
    for (int i = 1; i >= 0; i--) begin
      w = s[i*64 +: 64];
      if (w[63] && w[62:36] == pc[31:5]) begin
        p.hit = 1'b1;
        p.taken = w[5];
        p.target = {w[35:6], 2'b00};
      end
    end
    return p;
  endfunction

  // Scoreboard: pop on each prediction, push on each accepted lookup
  always @(negedge clk) begin
    if (rst_n) begin
      if (pred_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pred_unexpected: got hit=%0b taken=%0b tgt=%h, none expected",
                   pred_hit, pred_taken, pred_target);
        end else begin
          mon_e = exp_q.pop_front();
          if ({pred_hit, pred_taken, pred_target} !== mon_e) begin
            n_err++;
            $display("FAIL pred: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
                     pred_hit, pred_taken, pred_target, mon_e.hit, mon_e.taken, mon_e.target);
          end
        end
      end
      if (lookup_valid && lookup_ready) exp_q.push_back(ref_pred(lookup_pc));
    end
  end

  task automatic do_lookup(input logic [31:0] pc);
    @(posedge clk); #1;
    lookup_valid = 1'b1;
    lookup_pc = pc;
    @(negedge clk);
    n_cmp++;
    if (lookup_ready !== 1'b1) begin
      n_err++;
      $display("FAIL lookup_ready: got %0b want 1 (pc %h)", lookup_ready, pc);
    end
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    @(posedge clk); #1;
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = tk;
    upd_target = tgt;
    for (int i = 0; i < 20 && !upd_ready; i++) begin @(posedge clk); #1; end
    n_cmp++;
    if (upd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL upd_ready: got %0b want 1 (pc %h)", upd_ready, pc);
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    ref_mem[pc[4:2]] = ref_apply(ref_mem[pc[4:2]], pc, tk, tgt);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mem[pc[4:2]] !== ref_mem[pc[4:2]]) begin
      n_err++;
      $display("FAIL upd_store set %0d: got %h want %h", pc[4:2], mem[pc[4:2]], ref_mem[pc[4:2]]);
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({pred_valid, pred_hit, pred_taken, pred_target, upd_ready, lookup_ready,
         write_enable, init_done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: pv=%0b ph=%0b pt=%0b tgt=%h ur=%0b lr=%0b we=%0b id=%0b, want all 0",
               pred_valid, pred_hit, pred_taken, pred_target, upd_ready, lookup_ready,
               write_enable, init_done);
    end
  endtask

  task automatic test_init;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (write_enable !== 1'b1 || write_index !== 3'(i) || write_set !== '0 ||
          init_done !== 1'b0 || lookup_ready !== 1'b0 || upd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL init_sweep %0d: we=%0b idx=%0d set=%h done=%0b lr=%0b ur=%0b, want we=1 idx=%0d set=0 others 0",
                 i, write_enable, write_index, write_set, init_done, lookup_ready, upd_ready, i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (init_done !== 1'b1 || write_enable !== 1'b0 || lookup_ready !== 1'b1 || upd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL init_done: done=%0b we=%0b lr=%0b ur=%0b, want 1 0 1 1",
               init_done, write_enable, lookup_ready, upd_ready);
    end
    do_lookup(32'h100);
  endtask

  task automatic test_update_alloc;
    do_update(32'h1004, 1'b1, 32'h2000);
    n_cmp++;
    if (mem[1] !== {64'h0, 1'b1, 27'h80, 30'h800, 2'b10, 3'b000, 1'b1}) begin
      n_err++;
      $display("FAIL alloc_set1: got %h want way0 valid tag 80 tgt 800 cnt 2 lru 1", mem[1]);
    end
    do_lookup(32'h1004);
  endtask

  task automatic test_counter;
    logic [1:0] want [3];
    want[0] = 2'd1;
    want[1] = 2'd0;
    want[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      do_update(32'h1004, 1'b0, 32'h7777_0000);
      n_cmp++;
      if (mem[1][5:4] !== want[i]) begin
        n_err++;
        $display("FAIL counter step %0d: got %0d want %0d", i, mem[1][5:4], want[i]);
      end
      if (i == 1) do_lookup(32'h1004);
    end
  endtask

  task automatic test_replace;
    do_update(32'h1004, 1'b1, 32'h2000);
    do_update(32'h2004, 1'b1, 32'h3000);
    do_update(32'h3004, 1'b1, 32'h3100);
    n_cmp++;
    if (mem[1][62:36] !== 27'h180 || mem[1][127:64+36] !== 28'h8000100) begin
      n_err++;
      $display("FAIL replace_ways: got %h want way0 tag 180, way1 tag 100", mem[1]);
    end
    do_lookup(32'h1004);
    do_lookup(32'h2004);
    do_lookup(32'h3004);
    do_lookup(32'h0000_0e04);
  endtask

  task automatic test_starve;
    int hi;
    hi = 0;
    @(posedge clk); #1;
    lookup_valid = 1'b1;
    lookup_pc = 32'h100;
    upd_valid = 1'b1;
    upd_pc = 32'h1008;
    upd_taken = 1'b1;
    upd_target = 32'h4000;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    ref_mem[2] = ref_apply(ref_mem[2], 32'h1008, 1'b1, 32'h4000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (lookup_ready) hi++;
      else break;
    end
    n_cmp++;
    if (hi != STARVE_LIMIT || lookup_ready !== 1'b0) begin
      n_err++;
      $display("FAIL starve_cycles: got %0d ready cycles then ready=%0b, want %0d then 0",
               hi, lookup_ready, STARVE_LIMIT);
    end
    @(negedge clk);
    n_cmp++;
    if (write_enable !== 1'b1 || write_index !== 3'd2 || lookup_ready !== 1'b1) begin
      n_err++;
      $display("FAIL starve_write: we=%0b idx=%0d lr=%0b, want 1 2 1",
               write_enable, write_index, lookup_ready);
    end
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mem[2] !== ref_mem[2]) begin
      n_err++;
      $display("FAIL starve_store: got %h want %h", mem[2], ref_mem[2]);
    end
  endtask

  task automatic test_miss_not_taken;
    logic saw;
    saw = 1'b0;
    @(posedge clk); #1;
    upd_valid = 1'b1;
    upd_pc = 32'h5010;
    upd_taken = 1'b0;
    upd_target = 32'h9990;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (write_enable) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0 || upd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL miss_nt: write seen=%0b ready=%0b, want 0 1", saw, upd_ready);
    end
    do_lookup(32'h5010);
  endtask

  task automatic test_reset_mid_update;
    int waited;
    waited = 0;
    @(posedge clk); #1;
    upd_valid = 1'b1;
    upd_pc = 32'h6018;
    upd_taken = 1'b1;
    upd_target = 32'hABC0;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    @(negedge clk);
    while (!write_enable && waited < 10) begin @(negedge clk); waited++; end
    n_cmp++;
    if (write_enable !== 1'b1) begin
      n_err++;
      $display("FAIL rmw_reach_write: we=%0b want 1", write_enable);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pred_valid, pred_hit, pred_taken, pred_target, upd_ready, lookup_ready,
         write_enable, init_done} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: pv=%0b ph=%0b pt=%0b tgt=%h ur=%0b lr=%0b we=%0b id=%0b, want all 0",
               pred_valid, pred_hit, pred_taken, pred_target, upd_ready, lookup_ready,
               write_enable, init_done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem[6] !== '0) begin
      n_err++;
      $display("FAIL midreset_nowrite: set6 got %h want 0", mem[6]);
    end
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (write_enable !== 1'b1 || write_index !== 3'd0 || init_done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_sweep: we=%0b idx=%0d done=%0b, want 1 0 0",
               write_enable, write_index, init_done);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (init_done !== 1'b1 || mem[1] !== '0) begin
      n_err++;
      $display("FAIL midreset_done: done=%0b set1=%h, want 1 and 0", init_done, mem[1]);
    end
    do_lookup(32'h1004);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    test_reset;
    test_init;
    test_update_alloc;
    test_counter;
    test_replace;
    test_starve;
    test_miss_not_taken;
    test_reset_mid_update;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pred_drain: %0d predictions outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
